// File: rtl/writeback_stage_if.sv
// Bundle, bypass and register-file signals of the writeback stage.
// Handshake: there is no valid/ready pair here. A slot is taken on a rising
// edge when its valid and wb_en are high and interlock is low. Upstream must
// hold interlock high whenever stall_req is high. The rf_* outputs are a
// one-way write strobe with no back-pressure.
interface writeback_stage_if #(
    parameter int FIFO_DEPTH = 4,
    parameter int REG_ADDR_W = 5
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    // bundle from the memory stage
    logic                  interlock;
    logic                  u_valid;
    logic                  u_wb_en;
    logic                  u_is_load;
    logic [REG_ADDR_W-1:0] u_rd;
    logic [31:0]           u_alu_res;
    logic [31:0]           mem_douta;
    logic                  l_valid;
    logic                  l_wb_en;
    logic                  l_is_load;
    logic [REG_ADDR_W-1:0] l_rd;
    logic [31:0]           l_alu_res;
    logic [31:0]           mem_doutb;

    // bypass lookup into pending writes
    logic [REG_ADDR_W-1:0] byp_addr_a;
    logic [REG_ADDR_W-1:0] byp_addr_b;
    logic                  byp_hit_a;
    logic                  byp_hit_b;
    logic [31:0]           byp_data_a;
    logic [31:0]           byp_data_b;

    // register-file write port and flow control
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_waddr;
    logic [31:0]           rf_wdata;
    logic                  stall_req;
    logic [CNT_W-1:0]      pending_cnt;

    // upstream side: drives the bundle and lookups, observes results
    modport master (
        output interlock,
        output u_valid, u_wb_en, u_is_load, u_rd, u_alu_res, mem_douta,
        output l_valid, l_wb_en, l_is_load, l_rd, l_alu_res, mem_doutb,
        output byp_addr_a, byp_addr_b,
        input  byp_hit_a, byp_hit_b, byp_data_a, byp_data_b,
        input  rf_we, rf_waddr, rf_wdata, stall_req, pending_cnt
    );

    // writeback stage side
    modport slave (
        input  interlock,
        input  u_valid, u_wb_en, u_is_load, u_rd, u_alu_res, mem_douta,
        input  l_valid, l_wb_en, l_is_load, l_rd, l_alu_res, mem_doutb,
        input  byp_addr_a, byp_addr_b,
        output byp_hit_a, byp_hit_b, byp_data_a, byp_data_b,
        output rf_we, rf_waddr, rf_wdata, stall_req, pending_cnt
    );
endinterface

// File: rtl/writeback_stage.sv
// Writeback stage of the dual-issue core. Picks load or ALU data per slot,
// then serialises up to two register writes per bundle onto the single
// register-file write port. Writes that cannot go out this cycle wait in a
// small in-order FIFO, which is also searched for operand bypass.
module writeback_stage #(
    parameter int FIFO_DEPTH         = 4,
    parameter int REG_ADDR_W         = 5,
    parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
    input logic               clk,
    input logic               rst,
    writeback_stage_if.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // pending-write storage and bookkeeping
    logic [REG_ADDR_W-1:0] ent_addr [FIFO_DEPTH];
    logic [31:0]           ent_data [FIFO_DEPTH];
    logic [PTR_W-1:0]      head_ptr;
    logic [PTR_W-1:0]      tail_ptr;
    logic [CNT_W-1:0]      cnt;

    // registered write port
    logic                  rf_we_q;
    logic [REG_ADDR_W-1:0] rf_waddr_q;
    logic [31:0]           rf_wdata_q;

    // per-slot requests
    logic                  u_req_raw;
    logic                  u_req;
    logic                  l_req;
    logic [31:0]           u_data;
    logic [31:0]           l_data;

    // candidate routing for this cycle
    logic                  pop;
    logic                  out_v;
    logic [REG_ADDR_W-1:0] out_addr;
    logic [31:0]           out_data;
    logic                  push0_v;
    logic [REG_ADDR_W-1:0] push0_addr;
    logic [31:0]           push0_data;
    logic                  push1_v;
    logic [REG_ADDR_W-1:0] push1_addr;
    logic [31:0]           push1_data;
    logic [CNT_W-1:0]      n_push;

    // bypass results
    logic                  hit_a;
    logic                  hit_b;
    logic [31:0]           data_a;
    logic [31:0]           data_b;

    // Slot requests: interlock blocks acceptance; r0 writes vanish when hardwired.
    // If both slots target the same register the lower slot is younger, so the
    // upper write is dead and never needs to reach the register file.
    always_comb begin
        u_req_raw = bus.u_valid & bus.u_wb_en & ~bus.interlock &
                    ~(ZERO_REG_HARDWIRED & (bus.u_rd == '0));
        l_req     = bus.l_valid & bus.l_wb_en & ~bus.interlock &
                    ~(ZERO_REG_HARDWIRED & (bus.l_rd == '0));
        u_req     = u_req_raw & ~(l_req & (bus.u_rd == bus.l_rd));
        u_data    = bus.u_is_load ? bus.mem_douta : bus.u_alu_res;
        l_data    = bus.l_is_load ? bus.mem_doutb : bus.l_alu_res;
    end

    // Oldest candidate (FIFO head, then upper, then lower) goes to the write
    // port; whatever remains is pushed in program order.
    always_comb begin
        pop        = (cnt != '0);
        out_v      = 1'b0;
        out_addr   = '0;
        out_data   = '0;
        push0_v    = 1'b0;
        push0_addr = bus.l_rd;
        push0_data = l_data;
        push1_v    = 1'b0;
        push1_addr = bus.l_rd;
        push1_data = l_data;
        if (pop) begin
            out_v    = 1'b1;
            out_addr = ent_addr[head_ptr];
            out_data = ent_data[head_ptr];
            push0_v  = u_req | l_req;
            if (u_req) begin
                push0_addr = bus.u_rd;
                push0_data = u_data;
            end
            push1_v  = u_req & l_req;
        end else begin
            out_v    = u_req | l_req;
            if (u_req) begin
                out_addr = bus.u_rd;
                out_data = u_data;
            end else if (l_req) begin
                out_addr = bus.l_rd;
                out_data = l_data;
            end
            push0_v  = u_req & l_req;
        end
        n_push = CNT_W'(push0_v) + CNT_W'(push1_v);
    end

    // FIFO pointers and occupancy; wrap is modulo FIFO_DEPTH by pointer width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            cnt      <= '0;
        end else begin
            if (pop) begin
                head_ptr <= head_ptr + PTR_W'(1);
            end
            if (push1_v) begin
                tail_ptr <= tail_ptr + PTR_W'(2);
            end else if (push0_v) begin
                tail_ptr <= tail_ptr + PTR_W'(1);
            end
            cnt <= cnt - CNT_W'(pop) + n_push;
        end
    end

    // FIFO payload; contents are only meaningful below cnt, so no reset needed.
    always_ff @(posedge clk) begin
        if (push0_v) begin
            ent_addr[tail_ptr] <= push0_addr;
            ent_data[tail_ptr] <= push0_data;
        end
        if (push1_v) begin
            ent_addr[tail_ptr + PTR_W'(1)] <= push1_addr;
            ent_data[tail_ptr + PTR_W'(1)] <= push1_data;
        end
    end

    // Register-file write port, one write per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q    <= out_v;
            rf_waddr_q <= out_addr;
            rf_wdata_q <= out_data;
        end
    end

    // Bypass search from oldest to youngest so the youngest match is kept.
    // The value currently on rf_* is left to the register file's write-through.
    always_comb begin
        hit_a  = 1'b0;
        hit_b  = 1'b0;
        data_a = '0;
        data_b = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (CNT_W'(i) < cnt) begin
                if (ent_addr[head_ptr + PTR_W'(i)] == bus.byp_addr_a &&
                    !(ZERO_REG_HARDWIRED && bus.byp_addr_a == '0)) begin
                    hit_a  = 1'b1;
                    data_a = ent_data[head_ptr + PTR_W'(i)];
                end
                if (ent_addr[head_ptr + PTR_W'(i)] == bus.byp_addr_b &&
                    !(ZERO_REG_HARDWIRED && bus.byp_addr_b == '0)) begin
                    hit_b  = 1'b1;
                    data_b = ent_data[head_ptr + PTR_W'(i)];
                end
            end
        end
    end

    assign bus.rf_we       = rf_we_q;
    assign bus.rf_waddr    = rf_waddr_q;
    assign bus.rf_wdata    = rf_wdata_q;
    assign bus.pending_cnt = cnt;
    // Two pushes can arrive in one cycle, so warn one entry early.
    assign bus.stall_req   = (cnt >= CNT_W'(FIFO_DEPTH - 1));
    assign bus.byp_hit_a   = hit_a;
    assign bus.byp_hit_b   = hit_b;
    assign bus.byp_data_a  = data_a;
    assign bus.byp_data_b  = data_b;
endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed bundles, a program-order queue model
// checked on every falling edge, plus literal expectations at key points.
module tb_writeback_stage;
    localparam int DEPTH = 4;
    localparam int AW    = 5;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    writeback_stage_if #(.FIFO_DEPTH(DEPTH), .REG_ADDR_W(AW)) bus();

    writeback_stage #(
        .FIFO_DEPTH(DEPTH),
        .REG_ADDR_W(AW),
        .ZERO_REG_HARDWIRED(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: every accepted write not yet on rf_*, oldest first
    wr_t           q[$];
    wr_t           m_w;
    logic          m_ur;
    logic          m_lr;
    logic          exp_we   = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [31:0]   exp_data = '0;

    function automatic void byp_model(input logic [AW-1:0] a, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        if (a != '0) begin
            foreach (q[i]) begin
                if (q[i].a == a) begin
                    hit = 1'b1;
                    d   = q[i].d;
                end
            end
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            exp_we   = 1'b0;
            exp_addr = '0;
            exp_data = '0;
        end else begin
            m_ur = bus.u_valid && bus.u_wb_en && !bus.interlock && bus.u_rd != '0;
            m_lr = bus.l_valid && bus.l_wb_en && !bus.interlock && bus.l_rd != '0;
            if (m_ur && m_lr && bus.u_rd == bus.l_rd) m_ur = 1'b0;
            if (m_ur) q.push_back({bus.u_rd, bus.u_is_load ? bus.mem_douta : bus.u_alu_res});
            if (m_lr) q.push_back({bus.l_rd, bus.l_is_load ? bus.mem_doutb : bus.l_alu_res});
            if (q.size() > 0) begin
                m_w      = q.pop_front();
                exp_we   = 1'b1;
                exp_addr = m_w.a;
                exp_data = m_w.d;
            end else begin
                exp_we = 1'b0;
            end
            chk("no_overflow", 32'(q.size() <= DEPTH), 32'd1);
        end
    end

    // compare process on the falling edge
    always @(negedge clk) begin
        logic        h;
        logic [31:0] d;
        chk("m_rf_we", 32'(bus.rf_we), 32'(exp_we));
        if (exp_we) begin
            chk("m_rf_waddr", 32'(bus.rf_waddr), 32'(exp_addr));
            chk("m_rf_wdata", bus.rf_wdata, exp_data);
        end
        chk("m_pending_cnt", 32'(bus.pending_cnt), 32'(q.size()));
        chk("m_stall_req", 32'(bus.stall_req), 32'(q.size() >= DEPTH - 1));
        byp_model(bus.byp_addr_a, h, d);
        chk("m_byp_hit_a", 32'(bus.byp_hit_a), 32'(h));
        chk("m_byp_data_a", bus.byp_data_a, d);
        byp_model(bus.byp_addr_b, h, d);
        chk("m_byp_hit_b", 32'(bus.byp_hit_b), 32'(h));
        chk("m_byp_data_b", bus.byp_data_b, d);
    end

    // driver tasks
    task automatic drive_u(input logic ld, input logic [AW-1:0] rd, input logic [31:0] alu, input logic [31:0] mem);
        bus.u_valid = 1'b1; bus.u_wb_en = 1'b1; bus.u_is_load = ld;
        bus.u_rd = rd; bus.u_alu_res = alu; bus.mem_douta = mem;
    endtask

    task automatic drive_l(input logic ld, input logic [AW-1:0] rd, input logic [31:0] alu, input logic [31:0] mem);
        bus.l_valid = 1'b1; bus.l_wb_en = 1'b1; bus.l_is_load = ld;
        bus.l_rd = rd; bus.l_alu_res = alu; bus.mem_doutb = mem;
    endtask

    task automatic idle();
        bus.u_valid = 1'b0; bus.u_wb_en = 1'b0; bus.u_is_load = 1'b0;
        bus.u_rd = '0; bus.u_alu_res = '0; bus.mem_douta = '0;
        bus.l_valid = 1'b0; bus.l_wb_en = 1'b0; bus.l_is_load = 1'b0;
        bus.l_rd = '0; bus.l_alu_res = '0; bus.mem_doutb = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rf(input string name, input logic we, input logic [AW-1:0] a, input logic [31:0] d, input int cnt);
        chk({name, "_we"}, 32'(bus.rf_we), 32'(we));
        if (we) begin
            chk({name, "_waddr"}, 32'(bus.rf_waddr), 32'(a));
            chk({name, "_wdata"}, bus.rf_wdata, d);
        end
        chk({name, "_cnt"}, 32'(bus.pending_cnt), 32'(cnt));
    endtask

    // three dual bundles leaving r8 pending twice (0x4 older, 0x5 younger)
    task automatic fill_three();
        drive_u(1'b0, 5'd8, 32'h1, 32'h0);  drive_l(1'b0, 5'd9, 32'h2, 32'h0);  step();
        drive_u(1'b0, 5'd10, 32'h3, 32'h0); drive_l(1'b0, 5'd8, 32'h4, 32'h0);  step();
        drive_u(1'b0, 5'd8, 32'h5, 32'h0);  drive_l(1'b0, 5'd11, 32'h6, 32'h0); step();
        idle();
    endtask

    initial begin
        bus.interlock  = 1'b0;
        bus.byp_addr_a = '0;
        bus.byp_addr_b = '0;
        idle();

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk_rf("reset", 1'b0, '0, '0, 0);
        chk("reset_rf_waddr", 32'(bus.rf_waddr), 32'd0);
        chk("reset_rf_wdata", bus.rf_wdata, 32'd0);
        chk("reset_stall", 32'(bus.stall_req), 32'd0);
        chk("reset_hit_a", 32'(bus.byp_hit_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // single write
        drive_u(1'b0, 5'd3, 32'h11, 32'h0);
        step(); idle();
        chk_rf("single", 1'b1, 5'd3, 32'h11, 0);

        // dual write, distinct rd; upper is a load
        drive_u(1'b1, 5'd4, 32'h0, 32'hAA);
        drive_l(1'b0, 5'd5, 32'hBB, 32'h0);
        step(); idle();
        bus.byp_addr_a = 5'd5;
        #1;
        chk_rf("dual_e1", 1'b1, 5'd4, 32'hAA, 1);
        chk("dual_hit_a", 32'(bus.byp_hit_a), 32'd1);
        chk("dual_data_a", bus.byp_data_a, 32'hBB);
        step();
        chk_rf("dual_e2", 1'b1, 5'd5, 32'hBB, 0);
        chk("dual_e2_hit_a", 32'(bus.byp_hit_a), 32'd0);

        // same-rd collision
        drive_u(1'b0, 5'd7, 32'h1, 32'h0);
        drive_l(1'b0, 5'd7, 32'h2, 32'h0);
        step(); idle();
        chk_rf("collide", 1'b1, 5'd7, 32'h2, 0);
        step();
        chk_rf("collide_after", 1'b0, '0, '0, 0);

        // back-to-back dual writes up to stall, then drain under interlock
        drive_u(1'b0, 5'd1, 32'h101, 32'h0); drive_l(1'b0, 5'd2, 32'h102, 32'h0);
        step();
        chk_rf("b2b_1", 1'b1, 5'd1, 32'h101, 1);
        chk("b2b_1_stall", 32'(bus.stall_req), 32'd0);
        drive_u(1'b0, 5'd3, 32'h103, 32'h0); drive_l(1'b0, 5'd4, 32'h104, 32'h0);
        step();
        chk_rf("b2b_2", 1'b1, 5'd2, 32'h102, 2);
        chk("b2b_2_stall", 32'(bus.stall_req), 32'd0);
        drive_u(1'b0, 5'd5, 32'h105, 32'h0); drive_l(1'b0, 5'd6, 32'h106, 32'h0);
        step();
        bus.byp_addr_a = 5'd6;
        bus.byp_addr_b = 5'd4;
        #1;
        chk_rf("b2b_3", 1'b1, 5'd3, 32'h103, 3);
        chk("b2b_3_stall", 32'(bus.stall_req), 32'd1);
        chk("b2b_3_data_a", bus.byp_data_a, 32'h106);
        chk("b2b_3_data_b", bus.byp_data_b, 32'h104);
        // bundle left valid but blocked by interlock
        drive_u(1'b0, 5'd20, 32'hDEAD, 32'h0); drive_l(1'b0, 5'd21, 32'hBEEF, 32'h0);
        bus.interlock = 1'b1;
        step();
        chk_rf("drain_1", 1'b1, 5'd4, 32'h104, 2);
        chk("drain_1_stall", 32'(bus.stall_req), 32'd0);
        step();
        chk_rf("drain_2", 1'b1, 5'd5, 32'h105, 1);
        step();
        chk_rf("drain_3", 1'b1, 5'd6, 32'h106, 0);
        step();
        chk_rf("drain_4", 1'b0, '0, '0, 0);
        bus.interlock = 1'b0;
        idle();

        // youngest matching entry wins the bypass
        fill_three();
        bus.byp_addr_a = 5'd8;
        bus.byp_addr_b = 5'd11;
        #1;
        chk_rf("young", 1'b1, 5'd10, 32'h3, 3);
        chk("young_data_a", bus.byp_data_a, 32'h5);
        chk("young_data_b", bus.byp_data_b, 32'h6);
        bus.interlock = 1'b1;
        repeat (4) step();
        bus.interlock = 1'b0;

        // r0 filtering
        drive_u(1'b0, 5'd0, 32'hFF, 32'h0);
        drive_l(1'b0, 5'd0, 32'hEE, 32'h0);
        bus.byp_addr_a = 5'd0;
        step(); idle();
        chk_rf("r0", 1'b0, '0, '0, 0);
        chk("r0_hit_a", 32'(bus.byp_hit_a), 32'd0);
        chk("r0_data_a", bus.byp_data_a, 32'd0);

        // async reset with three pending writes, between edges
        fill_three();
        bus.interlock = 1'b1;
        bus.byp_addr_a = 5'd8;
        #2;
        chk("pre_rst_cnt", 32'(bus.pending_cnt), 32'd3);
        rst = 1'b1;
        #1;
        chk("async_rf_we", 32'(bus.rf_we), 32'd0);
        chk("async_cnt", 32'(bus.pending_cnt), 32'd0);
        chk("async_stall", 32'(bus.stall_req), 32'd0);
        chk("async_hit_a", 32'(bus.byp_hit_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.interlock = 1'b0;

        // after reset: a fresh write goes straight through
        drive_u(1'b0, 5'd12, 32'h1234, 32'h0);
        step(); idle();
        chk_rf("post_rst", 1'b1, 5'd12, 32'h1234, 0);
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage of the dual-issue (upper/lower slot) core. Sits directly downstream of the memory stage.
- Selects the per-slot result: load data from the memory stage, or the ALU result carried down the pipe.
- Serialises up to two register writes per bundle onto the single register-file write port, using a small pending-write FIFO.
- Exposes bypass lookup into pending writes and raises a stall request before the FIFO can overflow.

Parameters:
- FIFO_DEPTH, 4: pending-write entries, power of two, ≥2.
- REG_ADDR_W, 5: register address width.
- ZERO_REG_HARDWIRED, 1: when 1, writes to register 0 are discarded.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- interlock  input  1  global pipeline hold; bundle inputs ignored while high
- u_valid  input  1  upper slot carries an instruction
- u_wb_en  input  1  upper slot writes a register
- u_is_load  input  1  upper result comes from mem_douta
- u_rd  input  REG_ADDR_W  upper destination register
- u_alu_res  input  32  upper ALU result
- mem_douta  input  32  upper load data from memory stage
- l_valid, l_wb_en, l_is_load, l_rd, l_alu_res  input  as upper  lower slot equivalents
- mem_doutb  input  32  lower load data
- byp_addr_a, byp_addr_b  input  REG_ADDR_W  bypass lookup addresses
- byp_hit_a, byp_hit_b  output  1  address matches a pending FIFO entry
- byp_data_a, byp_data_b  output  32  data of youngest matching entry, 0 when no hit
- rf_we  output  1  register-file write enable
- rf_waddr  output  REG_ADDR_W  write address
- rf_wdata  output  32  write data
- stall_req  output  1  FIFO near full; upstream must assert interlock
- pending_cnt  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, immediate): rf_we=0, rf_waddr=0, rf_wdata=0, FIFO empty, pending_cnt=0, stall_req=0, byp_hit_*=0. Asserting rst mid-operation discards all pending writes.
- Slot write request: valid & wb_en & ~interlock & ~(ZERO_REG_HARDWIRED & rd==0).
- Slot data: is_load ? mem_dout : alu_res.
- Same-rd collision: if both slots request with equal rd, the upper request is dropped; lower is younger in program order.
- Program order of candidates each cycle, oldest first: FIFO head, then upper request, then lower request.
- Each rising edge, the oldest candidate is registered onto rf_we/rf_waddr/rf_wdata; all remaining candidates are pushed into the FIFO in order.
- rf_we=0 when there are no candidates.
- Direct-path latency: a request presented in the cycle before edge N appears on rf_* after edge N, i.e. one cycle.
- FIFO draining continues while interlock is high; only new bundle acceptance is blocked.
- Occupancy update: pending_cnt_next = pending_cnt − pop + pushes; pop ∈ {0,1}, pushes ∈ {0,1,2}.
- stall_req is driven combinationally from the count register only: stall_req = (pending_cnt ≥ FIFO_DEPTH−1).
- Overflow is a protocol violation. Upstream guarantees interlock whenever stall_req is high. The bench asserts that a push never occurs while full.
- Bypass is combinational over FIFO entries only; the youngest matching entry wins.
- Bypass address 0 never hits when ZERO_REG_HARDWIRED=1.
- A value on rf_* this cycle is not reported by bypass; the register file handles write-through.
- Pointer wrap-around is modulo FIFO_DEPTH.
- Full and empty are distinguished by pending_cnt, not by pointer equality.

Test Plan:
- Single write: u writes r3 with alu 0x11, l has no write, FIFO empty → after one edge rf_we=1, waddr=3, wdata=0x11; pending_cnt=0.
- Dual write, distinct rd: u r4 load with mem_douta=0xAA, l r5 alu=0xBB → edge 1: rf r4=0xAA, pending_cnt=1, byp_addr_a=5 gives hit with 0xBB. Edge 2, no new bundle: rf r5=0xBB, pending_cnt=0.
- Collision: u r7=0x1, l r7=0x2 → single write r7=0x2; pending_cnt stays 0.
- Back-to-back dual writes over 3 cycles, FIFO_DEPTH=4 → pending_cnt goes 1, 2, 3; stall_req rises at 3. With interlock held, the FIFO drains in program order and stall_req drops once pending_cnt=2.
- r0 filtering: u r0=0xFF, l r0=0xEE → rf_we stays 0; byp_addr_a=0 gives hit 0.
- Async reset with pending_cnt=3: assert rst between edges → rf_we=0, pending_cnt=0, stall_req=0 immediately, with no clock edge needed.
